// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller bundle: front-end, pc-block and IMEM handshake signals
interface fetch_ctrl_if #(
    parameter int PC_WIDTH = 32
);
    logic                flush;
    logic [PC_WIDTH-1:0] flush_target;
    logic                bp_take;
    logic [PC_WIDTH-1:0] bp_target;
    logic                ifu_stall;
    logic                halt_req;
    logic                imem_req_ready;
    logic                imem_rsp_valid;
    logic                imem_req_valid;
    logic                pc_load;
    logic [PC_WIDTH-1:0] pc_in;
    logic                pc_inc;
    logic                pc_stall;
    logic                pc_predict_take;
    logic [PC_WIDTH-1:0] pc_predict_target;
    logic                rsp_kill;
    logic                halt_ack;

    modport master (
        input  flush, flush_target, bp_take, bp_target, ifu_stall, halt_req,
               imem_req_ready, imem_rsp_valid,
        output imem_req_valid, pc_load, pc_in, pc_inc, pc_stall,
               pc_predict_take, pc_predict_target, rsp_kill, halt_ack
    );

    modport slave (
        output flush, flush_target, bp_take, bp_target, ifu_stall, halt_req,
               imem_req_ready, imem_rsp_valid,
        input  imem_req_valid, pc_load, pc_in, pc_inc, pc_stall,
               pc_predict_take, pc_predict_target, rsp_kill, halt_ack
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - pc sequencer and metered IMEM fetch issue with flush kill and halt/drain
// Optional perf counters enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
    parameter int PC_WIDTH        = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int BOOT_CYCLES     = 4
`ifdef FETCH_CTRL_PERF_EN
   ,parameter int PERF_WIDTH      = 32
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_ctrl_if.master    bus
`ifdef FETCH_CTRL_PERF_EN
   ,output logic [PERF_WIDTH-1:0] perf_stall_cnt_o,
    output logic [PERF_WIDTH-1:0] perf_flush_cnt_o
`endif
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUTSTANDING);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t              state_q;
    logic [BW-1:0]       boot_cnt_q;
    logic [CW-1:0]       out_cnt_q, out_cnt_d;
    logic [CW-1:0]       drop_cnt_q, drop_cnt_d;
    logic                pend_v_q, pend_v_d;
    logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic                halt_ack_q;
    logic                issue, predict;

    // Outputs are forced low while reset is asserted, even with live front-end inputs.
    always_comb begin
        bus.imem_req_valid = rst_n && (state_q == S_RUN) && !bus.ifu_stall && !bus.flush &&
                             ((out_cnt_q < MAX_CNT) || bus.imem_rsp_valid);
        issue              = bus.imem_req_valid && bus.imem_req_ready;
        predict            = !bus.flush && issue && (pend_v_q || bus.bp_take);
        bus.pc_load        = rst_n && bus.flush;
        bus.pc_in          = bus.pc_load ? bus.flush_target : '0;
        bus.pc_inc         = !bus.flush && issue && !predict;
        bus.pc_stall       = rst_n && bus.ifu_stall;
        bus.pc_predict_take   = predict;
        bus.pc_predict_target = !predict ? '0 : (bus.bp_take ? bus.bp_target : pend_tgt_q);
        bus.rsp_kill       = rst_n && bus.imem_rsp_valid && (drop_cnt_q != '0);
        bus.halt_ack       = halt_ack_q;

        out_cnt_d = out_cnt_q + CW'(issue) - CW'(bus.imem_rsp_valid);

        // After a flush every request still in flight belongs to the old path.
        drop_cnt_d = drop_cnt_q;
        if (bus.flush)
            drop_cnt_d = out_cnt_q - CW'(bus.imem_rsp_valid);
        else if (bus.rsp_kill)
            drop_cnt_d = drop_cnt_q - CW'(1);

        pend_v_d   = pend_v_q;
        pend_tgt_d = pend_tgt_q;
        if (bus.flush || predict) begin
            pend_v_d = 1'b0;
        end else if (bus.bp_take) begin
            pend_v_d   = 1'b1;
            pend_tgt_d = bus.bp_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            pend_v_q   <= 1'b0;
            pend_tgt_q <= '0;
            halt_ack_q <= 1'b0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            pend_v_q   <= pend_v_d;
            pend_tgt_q <= pend_tgt_d;
            case (state_q)
                S_BOOT: begin
                    if (boot_cnt_q == BOOT_LAST)
                        state_q <= S_RUN;
                    else
                        boot_cnt_q <= boot_cnt_q + BW'(1);
                end
                S_RUN: begin
                    if (bus.halt_req)
                        state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    // A dropped halt request wins over a drain that completes the same cycle.
                    if (!bus.halt_req) begin
                        state_q <= S_RUN;
                    end else if (out_cnt_d == '0) begin
                        state_q    <= S_HALTED;
                        halt_ack_q <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (!bus.halt_req) begin
                        state_q    <= S_RUN;
                        halt_ack_q <= 1'b0;
                    end
                end
                default: state_q <= S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.imem_rsp_valid && out_cnt_q == '0));
            assert (out_cnt_q <= MAX_CNT);
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [PERF_WIDTH-1:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if ((state_q == S_RUN) && !issue && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + PERF_WIDTH'(1);
            if (bus.flush && (perf_flush_q != '1))
                perf_flush_q <= perf_flush_q + PERF_WIDTH'(1);
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif
endmodule
